pipe_stage_reg: RTL and testbench

Parametrised pipeline boundary register between any two stages of the five-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces fixed-width latch-plus-hazard-clear registers with a valid/ready elastic stage.
- Includes a one-entry skid buffer, so `in_ready` comes from a register and back-pressure does not form a combinational path through the stage.
- Synchronous flush inserts a bubble whose data equals `RESET_VAL` (an all-zero NOP by default).

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_sat_counter.sv | 25 ++
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline boundary registers: the occupancy
// state encoding and the canonical NOP payload word.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } pipe_state_t;

    localparam logic [31:0] PIPE_NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones,
// cleared only by the asynchronous active-high reset.
module pipe_sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;

    // Count up on inc until the counter reaches all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline boundary register with a one-entry skid
// buffer. in_ready and out_valid decode straight from the state register,
// so downstream back-pressure never forms a combinational path upstream.
// Flush kills all held entries and leaves a RESET_VAL bubble.
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall/flush counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       WIDTH     = 64,
    parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(PIPE_NOP_WORD)
`ifdef PIPE_STAGE_PERF_EN
    , parameter int unsigned     CNT_WIDTH = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data
`ifdef PIPE_STAGE_PERF_EN
    , output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

    pipe_state_t      state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             emit;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign out_data  = main_q;

    // Handshake qualifiers for this cycle.
    always_comb begin
        accept = in_valid & in_ready;
        emit   = out_valid & out_ready;
    end

    // Occupancy FSM and payload registers; flush overrides every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else if (flush) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= ONE;
                        main_q  <= in_data;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_q  <= in_data;
                    end else if (accept) begin
                        state_q <= FULL;
                        skid_q  <= in_data;
                    end else if (emit) begin
                        state_q <= EMPTY;
                        main_q  <= RESET_VAL;
                    end
                end
                FULL: begin
                    if (emit) begin
                        state_q <= ONE;
                        main_q  <= skid_q;
                        skid_q  <= RESET_VAL;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    main_q  <= RESET_VAL;
                    skid_q  <= RESET_VAL;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic stall_inc;
    logic flush_inc;

    // Stall: upstream offering while the skid is occupied; flush: kill of live data.
    always_comb begin
        stall_inc = in_valid & ~in_ready;
        flush_inc = flush & (state_q != EMPTY);
    end

    pipe_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    pipe_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a FIFO scoreboard of expected
// output payloads, checked at every falling edge.
module tb_pipe_stage_reg;

    localparam int unsigned WIDTH = 64;
    localparam logic [WIDTH-1:0] RV = '0;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [1:0]       stall_cnt;
    logic [1:0]       flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] sb[$];

    pipe_stage_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RV)
`ifdef PIPE_STAGE_PERF_EN
        , .CNT_WIDTH (2)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare handshake flags and head payload, then
    // update the expected queue as the coming rising edge will.
    always @(negedge clk) begin
        if (!rst) begin
            check("sb_out_valid", WIDTH'(out_valid), WIDTH'(sb.size() != 0));
            check("sb_in_ready", WIDTH'(in_ready), WIDTH'(sb.size() < 2));
            if (sb.size() != 0) check("sb_out_data", out_data, sb[0]);
            else                check("sb_bubble", out_data, RV);
            if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
            if (in_valid && in_ready) sb.push_back(in_data);
            if (flush) sb.delete();
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", WIDTH'(out_valid), '0);
        check("rst_out_data", out_data, RV);
        check("rst_in_ready", WIDTH'(in_ready), 64'd1);
        rst = 1'b0;

        // 1: asynchronous reset while FULL
        step();
        in_valid = 1'b1; in_data = 64'hB; step();
        in_data = 64'hA; step();
        in_valid = 1'b0;
        check("t1_full_in_ready", WIDTH'(in_ready), '0);
        check("t1_full_head", out_data, 64'hB);
        #1 rst = 1'b1;
        #1;
        check("t1_async_out_valid", WIDTH'(out_valid), '0);
        check("t1_async_out_data", out_data, RV);
        check("t1_async_in_ready", WIDTH'(in_ready), 64'd1);
        rst = 1'b0;
        sb.delete();

        // 2: streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(i);
            step();
            check("t2_in_ready", WIDTH'(in_ready), 64'd1);
            check("t2_out_data", out_data, WIDTH'(i));
        end
        in_valid = 1'b0;
        step(); step();

        // 3: back-pressure through the skid entry
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h11; step();
        in_data = 64'h22; step();
        check("t3_full_in_ready", WIDTH'(in_ready), '0);
        in_data = 64'h33; step();
        check("t3_hold_data", out_data, 64'h11);
        check("t3_hold_valid", WIDTH'(out_valid), 64'd1);
        out_ready = 1'b1; step();
        check("t3_second", out_data, 64'h22);
        step();
        check("t3_third", out_data, 64'h33);
        in_valid = 1'b0; step();
        check("t3_drained", WIDTH'(out_valid), '0);
        step();

        // 4: flush while FULL with a concurrent offer
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hA1; step();
        in_data = 64'hA2; step();
        flush = 1'b1; in_data = 64'hA3; step();
        flush = 1'b0; in_valid = 1'b0;
        check("t4_out_valid", WIDTH'(out_valid), '0);
        check("t4_out_data", out_data, RV);
        check("t4_in_ready", WIDTH'(in_ready), 64'd1);
        out_ready = 1'b1; step(); step();

        // 5: simultaneous accept and emit in ONE
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h44; step();
        out_ready = 1'b1; in_data = 64'h55; step();
        in_valid = 1'b0;
        check("t5_out_valid", WIDTH'(out_valid), 64'd1);
        check("t5_out_data", out_data, 64'h55);
        check("t5_in_ready", WIDTH'(in_ready), 64'd1);
        step(); step();

`ifdef PIPE_STAGE_PERF_EN
        // 6: saturating perf counters
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        sb.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h1; step();
        in_data = 64'h2; step();
        for (int i = 0; i < 5; i++) step();
        check("t6_stall_cnt", WIDTH'(stall_cnt), 64'd3);
        in_valid = 1'b0;
        flush = 1'b1; step();
        flush = 1'b0;
        in_valid = 1'b1; in_data = 64'h3; step();
        in_valid = 1'b0;
        flush = 1'b1; step();
        flush = 1'b0; step();
        check("t6_flush_cnt", WIDTH'(flush_cnt), 64'd2);
        check("t6_stall_hold", WIDTH'(stall_cnt), 64'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
